// File: rtl/fm_demod_xprod.sv
// Cross-product FM discriminator: I/Q -> I[n-1]Q[n]-I[n]Q[n-1] -> N-tap running sum -> shift/saturate.
// Optional first-order de-emphasis output stage when FM_DEMOD_DEEMPH_EN is defined.
module fm_demod_xprod #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 12,
    parameter int AVG_LOG2     = 5,
    parameter int OUT_SHIFT    = 13,
    parameter int OFFSET_BIN   = 1,
    parameter int DEEMPH_SHIFT = 4
) (
    input  logic             data_clk,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  msi_i,
    input  logic [IN_W-1:0]  msi_q,
    input  logic             clear,
    output logic [OUT_W-1:0] demod_data,
    output logic             out_valid,
    output logic             sat,
    output logic             probe1
);
    localparam int N     = 1 << AVG_LOG2;
    localparam int P_W   = 2*IN_W + 1;
    localparam int ACC_W = P_W + AVG_LOG2;
    localparam int F_W   = AVG_LOG2 + 1;
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 8 || DEEMPH_SHIFT < 0) begin : g_bad_param
        $error("fm_demod_xprod: AVG_LOG2 must be 1..8, DEEMPH_SHIFT >= 0");
    end

    logic signed [IN_W-1:0]  new_i, new_q, cur_i, cur_q, prev_i, prev_q;
    logic                    primed;
    logic [2:0]              vld_pipe;   // [0] product token, [1] product ready, [2] window full
    logic signed [P_W-1:0]   prod_c, prod;
    logic signed [P_W-1:0]   pbuf [N];
    logic [AVG_LOG2-1:0]     wptr;
    logic [F_W-1:0]          fill;
    logic signed [ACC_W-1:0] acc, y;
    logic signed [OUT_W-1:0] y_sat;
    logic                    y_clip;

    // Flipping the MSB of an offset-binary word yields the two's-complement value.
    always_comb begin
        new_i = msi_i;
        new_q = msi_q;
        if (OFFSET_BIN != 0) begin
            new_i[IN_W-1] = ~msi_i[IN_W-1];
            new_q[IN_W-1] = ~msi_q[IN_W-1];
        end
    end

    always_comb prod_c = P_W'(prev_i) * P_W'(cur_q) - P_W'(cur_i) * P_W'(prev_q);

    always_ff @(posedge data_clk or posedge RST) begin
        if (RST) begin
            {cur_i, cur_q, prev_i, prev_q} <= '0;
            primed   <= 1'b0;
            vld_pipe <= '0;
            prod     <= '0;
            acc      <= '0;
            wptr     <= '0;
            fill     <= '0;
            for (int k = 0; k < N; k++) pbuf[k] <= '0;
        end else if (clear) begin
            {cur_i, cur_q, prev_i, prev_q} <= '0;
            primed   <= 1'b0;
            vld_pipe <= '0;
            prod     <= '0;
            acc      <= '0;
            wptr     <= '0;
            fill     <= '0;
            for (int k = 0; k < N; k++) pbuf[k] <= '0;
        end else begin
            vld_pipe[0] <= in_valid && primed;
            vld_pipe[1] <= vld_pipe[0];
            vld_pipe[2] <= vld_pipe[1] && (fill >= F_W'(N-1));
            if (in_valid) begin
                cur_i  <= new_i;
                cur_q  <= new_q;
                prev_i <= cur_i;
                prev_q <= cur_q;
                primed <= 1'b1;
            end
            if (vld_pipe[0]) prod <= prod_c;
            // Running sum: add the newest product, drop the one it overwrites.
            if (vld_pipe[1]) begin
                acc        <= acc + ACC_W'(prod) - ACC_W'(pbuf[wptr]);
                pbuf[wptr] <= prod;
                wptr       <= wptr + AVG_LOG2'(1);
                if (fill != F_W'(N)) fill <= fill + F_W'(1);
            end
        end
    end

    always_comb begin
        y      = acc >>> OUT_SHIFT;
        y_sat  = y[OUT_W-1:0];
        y_clip = 1'b0;
        if (y > Y_MAX) begin
            y_sat  = Y_MAX[OUT_W-1:0];
            y_clip = 1'b1;
        end else if (y < Y_MIN) begin
            y_sat  = Y_MIN[OUT_W-1:0];
            y_clip = 1'b1;
        end
    end

`ifdef FM_DEMOD_DEEMPH_EN
    localparam int D_W = OUT_W + DEEMPH_SHIFT;
    logic signed [OUT_W-1:0] ys_r;
    logic                    clip_r, sgn_r, s3_vld;
    logic signed [D_W-1:0]   d_acc, d_nxt;
    logic signed [D_W:0]     d_diff;

    // d_acc holds DEEMPH_SHIFT fractional bits below the integer output word.
    always_comb begin
        d_diff = {ys_r[OUT_W-1], ys_r, {DEEMPH_SHIFT{1'b0}}} - {d_acc[D_W-1], d_acc};
        d_nxt  = d_acc + D_W'(d_diff >>> DEEMPH_SHIFT);
    end

    always_ff @(posedge data_clk or posedge RST) begin
        if (RST) begin
            {ys_r, clip_r, sgn_r, s3_vld, d_acc} <= '0;
            {demod_data, out_valid, sat, probe1} <= '0;
        end else if (clear) begin
            {ys_r, clip_r, sgn_r, s3_vld, d_acc} <= '0;
            {demod_data, out_valid, sat, probe1} <= '0;
        end else begin
            s3_vld    <= vld_pipe[2];
            out_valid <= s3_vld;
            if (vld_pipe[2]) begin
                ys_r   <= y_sat;
                clip_r <= y_clip;
                sgn_r  <= acc[ACC_W-1];
            end
            if (s3_vld) begin
                d_acc      <= d_nxt;
                demod_data <= d_nxt[D_W-1:DEEMPH_SHIFT];
                sat        <= clip_r;
                probe1     <= sgn_r;
            end
        end
    end
`else
    always_ff @(posedge data_clk or posedge RST) begin
        if (RST) begin
            {demod_data, out_valid, sat, probe1} <= '0;
        end else if (clear) begin
            {demod_data, out_valid, sat, probe1} <= '0;
        end else begin
            out_valid <= vld_pipe[2];
            if (vld_pipe[2]) begin
                demod_data <= y_sat;
                sat        <= y_clip;
                probe1     <= acc[ACC_W-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fm_demod_xprod.sv
// Directed bench: two instances (two's complement and offset binary) fed equivalent samples.
module tb_fm_demod_xprod;
    localparam int HN = 4096;

    logic        data_clk = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] i_tc = '0, q_tc = '0, i_ob = '0, q_ob = '0;
    logic [11:0] d_tc, d_ob;
    logic        ov_tc, ov_ob, sat_tc, sat_ob, p_tc, p_ob;

    int ntest = 0, nfail = 0;
    int cyc = 0, ins = 0, nov = 0, first_cyc = -1, e33 = -1;
    int hist [HN];
    int exp_d = 0, exp_s = 0, exp_p = 0;

    typedef struct {
        string nm;
        int    amp;
        int    dir;
        int    d;
        int    s;
        int    p;
    } vec_t;
    vec_t vt [5];

    fm_demod_xprod #(.OFFSET_BIN(0)) dut_tc (
        .data_clk(data_clk), .RST(RST), .in_valid(in_valid), .msi_i(i_tc), .msi_q(q_tc),
        .clear(clear), .demod_data(d_tc), .out_valid(ov_tc), .sat(sat_tc), .probe1(p_tc));

    fm_demod_xprod #(.OFFSET_BIN(1)) dut_ob (
        .data_clk(data_clk), .RST(RST), .in_valid(in_valid), .msi_i(i_ob), .msi_q(q_ob),
        .clear(clear), .demod_data(d_ob), .out_valid(ov_ob), .sat(sat_ob), .probe1(p_ob));

    always #5 data_clk = ~data_clk;

    task automatic chk(string nm, int act, int exp);
        ntest++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_out(string tag, int ov, int d, int s, int p);
        chk({tag, "_ov_tc"}, int'(ov_tc), ov);
        chk({tag, "_ov_ob"}, int'(ov_ob), ov);
        chk({tag, "_data_tc"}, $signed(d_tc), d);
        chk({tag, "_data_ob"}, $signed(d_ob), d);
        chk({tag, "_sat_tc"}, int'(sat_tc), s);
        chk({tag, "_sat_ob"}, int'(sat_ob), s);
        chk({tag, "_probe_tc"}, int'(p_tc), p);
        chk({tag, "_probe_ob"}, int'(p_ob), p);
    endtask

    // One clock: bookkeeping of sampled inputs, then output checks 1 time unit after the edge.
    task automatic tick();
        bit exp_ov;
        @(posedge data_clk);
        cyc++;
        hist[cyc % HN] = 0;
        if (RST || clear) begin
            ins = 0;
            for (int j = 0; j < 4; j++) if (cyc >= j) hist[(cyc - j) % HN] = 0;
        end else if (in_valid) begin
            ins++;
            hist[cyc % HN] = ins;
            if (ins == 33) e33 = cyc;
        end
        exp_ov = (cyc >= 3) && (hist[(cyc - 3) % HN] >= 33);
        #1;
        chk("ov_tc", int'(ov_tc), int'(exp_ov));
        chk("ov_ob", int'(ov_ob), int'(exp_ov));
        if (ov_tc) begin
            nov++;
            if (nov == 1) first_cyc = cyc;
        end
        if (exp_ov) begin
            chk("data_tc", $signed(d_tc), exp_d);
            chk("data_ob", $signed(d_ob), exp_d);
            chk("sat_tc", int'(sat_tc), exp_s);
            chk("sat_ob", int'(sat_ob), exp_s);
            chk("probe_tc", int'(p_tc), exp_p);
            chk("probe_ob", int'(p_ob), exp_p);
        end
    endtask

    // dir +1: counter-clockwise, -1: clockwise, 0: constant (amp, amp).
    task automatic set_sample(int amp, int dir, int k);
        int si, sq;
        case (k % 4)
            0:       begin si = amp;  sq = 0;          end
            1:       begin si = 0;    sq = dir * amp;  end
            2:       begin si = -amp; sq = 0;          end
            default: begin si = 0;    sq = -dir * amp; end
        endcase
        if (dir == 0) begin si = amp; sq = amp; end
        i_tc = 12'(si);
        q_tc = 12'(sq);
        i_ob = i_tc ^ 12'h800;
        q_ob = q_tc ^ 12'h800;
    endtask

    task automatic run_seg(int amp, int dir, int k0, int n, bit gaps);
        for (int k = k0; k < k0 + n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat (2 + (((k % 5) == 0) ? $urandom_range(0, 4) : 0)) tick();
            end
            set_sample(amp, dir, k);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        RST      = 1'b1;
        #1;
        chk_out("rst", 0, 0, 0, 0);
        tick();
        tick();
        RST       = 1'b0;
        nov       = 0;
        first_cyc = -1;
        e33       = -1;
    endtask

    task automatic set_exp(int d, int s, int p);
        exp_d = d;
        exp_s = s;
        exp_p = p;
    endtask

    initial begin
        // 32 products of +/-62500 (or +/-1e6) summed, then >>> 13.
        vt[0] = '{"rot250_ccw",   250,  1,   244, 0, 0};
        vt[1] = '{"rot250_cw",    250, -1,  -245, 0, 1};
        vt[2] = '{"rot1000_ccw", 1000,  1,  2047, 1, 0};
        vt[3] = '{"rot1000_cw",  1000, -1, -2048, 1, 1};
        vt[4] = '{"const300",     300,  0,     0, 0, 0};

        #2;
        foreach (vt[v]) begin
            do_reset();
            set_exp(vt[v].d, vt[v].s, vt[v].p);
            run_seg(vt[v].amp, vt[v].dir, 0, 40, 1'b0);
            drain();
            chk({vt[v].nm, "_n_out"}, nov, 40 - 33 + 1);
            chk({vt[v].nm, "_latency"}, first_cyc - e33, 3);
        end

        // Sparse in_valid with random gaps: same values, same count rule.
        do_reset();
        set_exp(244, 0, 0);
        run_seg(250, 1, 0, 45, 1'b1);
        drain();
        chk("gaps_n_out", nov, 45 - 33 + 1);
        chk("gaps_latency", first_cyc - e33, 3);

        // clear concurrent with a valid sample after 50 inputs.
        do_reset();
        set_exp(244, 0, 0);
        run_seg(250, 1, 0, 50, 1'b0);
        chk("pre_clear_data", $signed(d_tc), 244);
        set_sample(250, 1, 50);
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk_out("clear", 0, 0, 0, 0);
        nov = 0;
        first_cyc = -1;
        e33 = -1;
        run_seg(250, 1, 51, 40, 1'b0);
        drain();
        chk("clear_n_out", nov, 40 - 33 + 1);
        chk("clear_latency", first_cyc - e33, 3);

        // Asynchronous reset between edges, then a clean restart.
        do_reset();
        set_exp(244, 0, 0);
        run_seg(250, 1, 0, 50, 1'b0);
        chk("pre_rst_data", $signed(d_tc), 244);
        #3;
        do_reset();
        run_seg(250, 1, 0, 40, 1'b0);
        drain();
        chk("restart_n_out", nov, 40 - 33 + 1);
        chk("restart_latency", first_cyc - e33, 3);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/fm_demod_xprod.md
Name: fm_demod_xprod

Overview:
Parametrised cross-product FM discriminator for the MSI I/Q baseband path. It takes I/Q sample pairs qualified by a valid strobe and forms the per-sample cross product I[n-1]·Q[n] − I[n]·Q[n-1]. That product is smoothed by a power-of-two running-sum moving average, then scaled and saturated to a signed audio word with an output valid strobe. It supports offset-binary or two's-complement input and a flush control.

Parameters:
IN_W, 12, I/Q input width
OUT_W, 12, demodulated output width (signed)
AVG_LOG2, 5, log2 of moving-average length N (N=32 default; legal 1..8)
OUT_SHIFT, 13, arithmetic right shift applied to accumulator before saturation
OFFSET_BIN, 1, 1: inputs offset binary (midscale 2^(IN_W-1) = zero); 0: two's complement
DEEMPH_SHIFT, 4, de-emphasis coefficient shift (used only with optional feature)

Ports:
data_clk  in  1  sample clock
RST  in  1  asynchronous reset, active-high
in_valid  in  1  qualifies msi_i/msi_q this cycle
msi_i  in  IN_W  in-phase sample
msi_q  in  IN_W  quadrature sample
clear  in  1  synchronous flush of all datapath state
demod_data  out  OUT_W  signed demodulated sample
out_valid  out  1  one-cycle strobe, demod_data new
sat  out  1  high with out_valid when the current output was clipped
probe1  out  1  sign of accumulator (debug)

Behaviour:
- RST high (async): all registers 0; demod_data=0, out_valid=0, sat=0, probe1=0; history buffer, accumulator, fill counter and prime flag all cleared.
- Input conversion: OFFSET_BIN=1 inverts the MSB (equivalent to subtracting midscale). Samples are treated as signed IN_W.
- Pipeline advances only on valid tokens; stalls hold all state. Gaps of any length in in_valid are transparent.
  - S0 (edge sampling in_valid): cur<=new sample, prev<=old cur.
  - S1: product = prev_i*cur_q − cur_i*prev_q, signed, width 2*IN_W+1, no truncation.
  - S2: circular buffer of N products, write pointer wraps N-1 -> 0. acc <= acc + product − buf[wptr]; buf[wptr] <= product. acc width 2*IN_W+1+AVG_LOG2.
  - S3: y = acc >>> OUT_SHIFT, saturated to [−2^(OUT_W-1), 2^(OUT_W-1)−1]. sat=1 iff clipped. Registered to demod_data.
- Latency: out_valid asserts on the 3rd edge after the edge sampling the valid input, when that input produced a product and the buffer is full.
- Prime: the first valid sample after reset or clear only loads cur; it generates no product token.
- Warm-up: the fill counter counts products entering S2 and saturates at N. out_valid is suppressed until the N-th product has entered, so the first out_valid follows the (N+1)-th valid input.
- clear: zeroes buffer, acc, fill counter, prime flag, valid tokens and outputs next edge. in_valid coincident with clear is dropped. clear wins over every other event.
- Accumulator cannot overflow by construction; wrap-around applies only to the pointer.
- probe1 = acc MSB, registered with demod_data.
- demod_data and sat hold their values between out_valid strobes.

Optional Feature:
FM_DEMOD_DEEMPH_EN
- Defined: an extra stage after S3 applies a first-order de-emphasis, d <= d + ((y_sat − d) >>> DEEMPH_SHIFT), with d OUT_W+DEEMPH_SHIFT wide internally. demod_data = d truncated to its integer part. Latency becomes 4. The stage state is cleared by RST and clear.
- Undefined: the stage is absent; latency is 3 and demod_data = y_sat.

Test Plan:
1. Two's complement (OFFSET_BIN=0), defaults: repeat (250,0),(0,250),(−250,0),(0,−250). Required: first out_valid after the 33rd input; demod_data=244 (2,000,000>>>13), sat=0.
2. Same stimulus, reverse rotation: demod_data=−245, probe1=1. Same stimulus at amplitude 1000: demod_data=2047, sat=1. Its reverse rotation: demod_data=−2048, sat=1.
3. OFFSET_BIN=1, constant I=Q=2048+300 for 40 samples: demod_data=0, sat=0. Rotating offset-binary version of test 1: demod_data=244.
4. Test 1 with in_valid asserted only every 3rd cycle and random gaps: output sequence identical to test 1, out_valid count = inputs − 33 + 1.
5. clear asserted mid-stream after 50 inputs, concurrent with in_valid: that sample is dropped, out_valid=0 next edge. The next out_valid follows the 33rd subsequent input, value 244.
6. RST pulsed mid-stream (async, between edges): all outputs read 0 immediately. The restart behaves exactly as test 1.
